// File: rtl/count_checker.sv
// Sequence checker for an upstream modulo-2^Size counter, with a valid/ready event FIFO.
// Optional build macro COUNT_CHECKER_STALL_EN reports a repeated count while locked as a STALL event.
module count_checker #(
  parameter int Size     = 5,
  parameter int Depth    = 4,
  parameter int ErrWidth = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [Size-1:0]     count,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [1:0]          evt_kind,
  output logic [Size-1:0]     evt_value,
  output logic [7:0]          wrap_count,
  output logic [ErrWidth-1:0] error_count,
  output logic                locked,
  output logic                overflow
);

  localparam int AddrW = $clog2(Depth);
  localparam int PtrW  = AddrW + 1;

  localparam logic [1:0] KindWrap     = 2'd0;
  localparam logic [1:0] KindMismatch = 2'd1;
`ifdef COUNT_CHECKER_STALL_EN
  localparam logic [1:0] KindStall    = 2'd2;
`endif

  typedef enum logic [1:0] {
    UNLOCKED,
    LOCKED,
    RESYNC
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [Size-1:0]   prev;
  logic [Size-1:0]   exp_count;
  logic              is_exp;
  logic              at_top;
  logic              push_req;
  logic [1:0]        push_kind;
  logic              err_inc;
  logic              wrap_inc;

  logic [Size+1:0]   mem [Depth];
  logic [PtrW-1:0]   wr_ptr;
  logic [PtrW-1:0]   rd_ptr;
  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;
  logic              push_ok;
  logic              drop;
  logic [Size+1:0]   head;

  assign exp_count = prev + Size'(1);
  assign is_exp    = (count == exp_count);
  assign at_top    = (prev == '1);

  always_comb begin
    next_state = state;
    push_req   = 1'b0;
    push_kind  = KindWrap;
    err_inc    = 1'b0;
    wrap_inc   = 1'b0;
    if (enable) begin
      case (state)
        UNLOCKED: next_state = LOCKED;
        LOCKED: begin
          if (is_exp) begin
            if (at_top) begin
              push_req = 1'b1;
              wrap_inc = 1'b1;
            end
          end else if (count == prev) begin
`ifdef COUNT_CHECKER_STALL_EN
            push_req  = 1'b1;
            push_kind = KindStall;
            err_inc   = 1'b1;
`endif
          end else begin
            push_req   = 1'b1;
            push_kind  = KindMismatch;
            err_inc    = 1'b1;
            next_state = RESYNC;
          end
        end
        RESYNC: begin
          // Further bad samples only bump the tally so one fault cannot flood the FIFO.
          if (is_exp) begin
            next_state = LOCKED;
            if (at_top) begin
              push_req = 1'b1;
              wrap_inc = 1'b1;
            end
          end else begin
            err_inc = 1'b1;
          end
        end
        default: next_state = UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= UNLOCKED;
      prev        <= '0;
      wrap_count  <= '0;
      error_count <= '0;
    end else begin
      state <= next_state;
      if (enable) begin
        prev <= count;
      end
      if (wrap_inc) begin
        wrap_count <= wrap_count + 8'd1;
      end
      if (err_inc && (error_count != '1)) begin
        error_count <= error_count + ErrWidth'(1);
      end
    end
  end

  assign locked = (state == LOCKED);

  // Extra pointer MSB separates full from empty when the index bits match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AddrW] != rd_ptr[AddrW]) &&
                      (wr_ptr[AddrW-1:0] == rd_ptr[AddrW-1:0]);
  assign pop        = !fifo_empty && evt_ready;
  assign push_ok    = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PtrW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PtrW'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr[AddrW-1:0]] <= {push_kind, count};
    end
  end

  assign head      = mem[rd_ptr[AddrW-1:0]];
  assign evt_valid = !fifo_empty;
  assign evt_kind  = evt_valid ? head[Size+1:Size] : 2'd0;
  assign evt_value = evt_valid ? head[Size-1:0] : '0;

endmodule

// File: tb/tb_count_checker.sv
// Directed bench for count_checker with immediate-assertion checks and a pop recorder.
// Expectations for the repeated-count step follow COUNT_CHECKER_STALL_EN.
module tb_count_checker;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [4:0] count;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_kind;
  logic [4:0] evt_value;
  logic [7:0] wrap_count;
  logic [7:0] error_count;
  logic       locked;
  logic       overflow;

  int total;
  int bad;
  int pops;
  int base;
  logic [1:0] rec_kind [32];
  logic [4:0] rec_val  [32];

  count_checker #(.Size(5), .Depth(4), .ErrWidth(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .count       (count),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_kind    (evt_kind),
    .evt_value   (evt_value),
    .wrap_count  (wrap_count),
    .error_count (error_count),
    .locked      (locked),
    .overflow    (overflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // A head seen with ready high just before an edge is popped by that edge.
  task automatic record();
    if (evt_valid && evt_ready && pops < 32) begin
      rec_kind[pops] = evt_kind;
      rec_val[pops]  = evt_value;
      pops++;
    end
  endtask

  task automatic samp(input logic [4:0] c);
    count  = c;
    enable = 1'b1;
    record();
    @(posedge clock);
    #1;
    enable = 1'b0;
  endtask

  task automatic tick();
    enable = 1'b0;
    record();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    pops      = 0;
    reset     = 1'b0;
    enable    = 1'b0;
    count     = 5'd0;
    evt_ready = 1'b1;
    #2;

    check("rst_valid", 32'(evt_valid), 0);
    check("rst_kind", 32'(evt_kind), 0);
    check("rst_value", 32'(evt_value), 0);
    check("rst_wrap", 32'(wrap_count), 0);
    check("rst_err", 32'(error_count), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_ovf", 32'(overflow), 0);
    do_reset();

    // 1: full ascending run with one wrap
    samp(5'd0);
    check("t1_locked", 32'(locked), 1);
    for (int i = 1; i < 32; i++) samp(5'(i));
    samp(5'd0);
    samp(5'd1);
    tick();
    check("t1_pops", 32'(pops), 1);
    check("t1_kind", 32'(rec_kind[0]), 0);
    check("t1_value", 32'(rec_val[0]), 0);
    check("t1_wrap", 32'(wrap_count), 1);
    check("t1_err", 32'(error_count), 0);

    // 2: mismatch then resync
    base = pops;
    samp(5'd2); samp(5'd3); samp(5'd4); samp(5'd5);
    samp(5'd9);
    check("t2_unlocked", 32'(locked), 0);
    samp(5'd12);
    samp(5'd13);
    check("t2_relocked", 32'(locked), 1);
    check("t2_pops", 32'(pops - base), 1);
    check("t2_kind", 32'(rec_kind[base]), 1);
    check("t2_value", 32'(rec_val[base]), 9);
    check("t2_err", 32'(error_count), 2);

    // 3: six mismatches with no consumer
    evt_ready = 1'b0;
    samp(5'd20); samp(5'd21);
    samp(5'd25); samp(5'd26);
    samp(5'd2);  samp(5'd3);
    samp(5'd10); samp(5'd11);
    samp(5'd15); samp(5'd16);
    samp(5'd30); samp(5'd31);
    check("t3_valid", 32'(evt_valid), 1);
    check("t3_ovf", 32'(overflow), 1);
    check("t3_head", 32'(evt_value), 20);
    check("t3_err", 32'(error_count), 8);
    base = pops;
    evt_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("t3_pops", 32'(pops - base), 4);
    check("t3_ord0", 32'(rec_val[base]), 20);
    check("t3_ord1", 32'(rec_val[base+1]), 25);
    check("t3_ord2", 32'(rec_val[base+2]), 2);
    check("t3_ord3", 32'(rec_val[base+3]), 10);
    check("t3_empty", 32'(evt_valid), 0);

    // 4: push into a full FIFO while the head pops
    do_reset();
    evt_ready = 1'b0;
    samp(5'd0);
    samp(5'd5);  samp(5'd6);
    samp(5'd9);  samp(5'd10);
    samp(5'd20); samp(5'd21);
    samp(5'd1);  samp(5'd2);
    check("t4_full_valid", 32'(evt_valid), 1);
    check("t4_full_ovf", 32'(overflow), 0);
    base = pops;
    evt_ready = 1'b1;
    samp(5'd8);
    check("t4_ovf", 32'(overflow), 0);
    check("t4_newhead", 32'(evt_value), 9);
    for (int i = 0; i < 5; i++) tick();
    check("t4_pops", 32'(pops - base), 5);
    check("t4_ord0", 32'(rec_val[base]), 5);
    check("t4_ord1", 32'(rec_val[base+1]), 9);
    check("t4_ord2", 32'(rec_val[base+2]), 20);
    check("t4_ord3", 32'(rec_val[base+3]), 1);
    check("t4_ord4", 32'(rec_val[base+4]), 8);
    check("t4_empty", 32'(evt_valid), 0);

    // 5: repeated count while locked
    do_reset();
    base = pops;
    samp(5'd6);
    samp(5'd7);
    samp(5'd7);
    samp(5'd8);
    tick();
    check("t5_locked", 32'(locked), 1);
`ifdef COUNT_CHECKER_STALL_EN
    check("t5_pops", 32'(pops - base), 1);
    check("t5_kind", 32'(rec_kind[base]), 2);
    check("t5_value", 32'(rec_val[base]), 7);
    check("t5_err", 32'(error_count), 1);
`else
    check("t5_pops", 32'(pops - base), 0);
    check("t5_err", 32'(error_count), 0);
`endif

    // 6: asynchronous reset with events pending
    do_reset();
    evt_ready = 1'b0;
    samp(5'd0);
    samp(5'd5);  samp(5'd6);
    samp(5'd9);  samp(5'd10);
    samp(5'd20); samp(5'd21);
    check("t6_err_pre", 32'(error_count), 3);
    check("t6_valid_pre", 32'(evt_valid), 1);
    #1;
    reset = 1'b0;
    #1;
    check("t6_valid", 32'(evt_valid), 0);
    check("t6_kind", 32'(evt_kind), 0);
    check("t6_value", 32'(evt_value), 0);
    check("t6_wrap", 32'(wrap_count), 0);
    check("t6_err", 32'(error_count), 0);
    check("t6_locked", 32'(locked), 0);
    check("t6_ovf", 32'(overflow), 0);
    @(negedge clock);
    reset = 1'b1;
    evt_ready = 1'b1;
    @(posedge clock);
    #1;
    samp(5'd17);
    check("t6_relock", 32'(locked), 1);
    check("t6_noevt", 32'(evt_valid), 0);
    samp(5'd18);
    check("t6_noevt2", 32'(evt_valid), 0);
    check("t6_err_post", 32'(error_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/count_checker.md
Name: count_checker

Overview:
- Downstream consumer of the `counter` block's `count` output.
- Samples `count` on each enabled clock and checks that it advances by exactly +1 modulo 2^Size.
- Reports wrap-around and sequence errors as events through a small valid/ready event FIFO, read by the Ruby-side bench or a logger.
- Keeps running wrap and error tallies.

Parameters:
- Size, 5, width of the sampled count; must match the upstream counter.
- Depth, 4, event FIFO entries; power of two, minimum 2.
- ErrWidth, 8, width of the saturating error counter.

Ports:
- clock  input  1  rising-edge clock shared with the counter.
- reset  input  1  asynchronous, active-low reset; all state is cleared while low.
- enable  input  1  sample strobe; `count` is examined only on edges where enable=1.
- count  input  Size  value driven by the upstream counter.
- evt_valid  output  1  FIFO head holds an event.
- evt_ready  input  1  consumer accepts the head event on an edge where evt_valid=1.
- evt_kind  output  2  event type: 0=WRAP, 1=MISMATCH, 2=STALL, 3=reserved.
- evt_value  output  Size  sampled `count` that produced the event.
- wrap_count  output  8  number of WRAP events, modulo 256.
- error_count  output  ErrWidth  number of errored samples; saturates at all-ones.
- locked  output  1  1 when the FSM is in LOCKED.
- overflow  output  1  sticky; an event was dropped because the FIFO was full.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM=UNLOCKED; prev=0.
  - FIFO emptied: evt_valid=0; evt_kind and evt_value read 0.
  - wrap_count=0, error_count=0, locked=0, overflow=0.
- Definitions: exp = prev+1 mod 2^Size. Every enabled sample loads prev<=count, unless stated otherwise below.
- FSM state UNLOCKED:
  - First enabled sample loads prev and goes to LOCKED.
  - No event and no check on that sample.
- FSM state LOCKED, enabled sample:
  - count==exp and prev==2^Size-1 (so count==0): push WRAP; wrap_count++.
  - count==exp otherwise: no event.
  - count==prev: behaviour depends on the optional feature.
  - Any other value: push MISMATCH; error_count++; go to RESYNC.
- FSM state RESYNC, enabled sample:
  - count==exp: go to LOCKED, no event; a WRAP is still pushed if the wrap condition holds.
  - Any other value: error_count++, no event pushed (flood suppression); stay in RESYNC.
- enable=0: no state, prev, or counter change.
- Latency: an event produced by the sample at edge N is written at edge N; evt_valid is 1 after edge N if the FIFO was empty. Zero extra bubbles.
- FIFO handshake:
  - Pop occurs on an edge where evt_valid and evt_ready are both 1.
  - Head outputs are stable while evt_valid=1 and evt_ready=0.
  - Strict FIFO order.
- FIFO full, no pop on this edge: the new event is dropped, overflow<=1, and the counters still update.
- FIFO full with a pop on the same edge: push is accepted; occupancy is unchanged.
- FIFO empty with simultaneous push: the pushed event appears at the head; evt_ready has no effect that cycle.
- Pointers: log2(Depth)+1 bits, wrap naturally. Full = MSBs differ and low bits equal.
- error_count saturates and holds at 2^ErrWidth-1. wrap_count rolls over 255 to 0.
- Reset asserted mid-operation: everything is cleared immediately, including pending FIFO events. The first enabled sample after release re-locks.

Optional Feature:
- Macro: COUNT_CHECKER_STALL_EN.
- Defined: count==prev in LOCKED pushes STALL; error_count++; FSM stays LOCKED.
- Not defined: count==prev in LOCKED is a silent hold, with no event and no counter change. Kind 2 is never produced.
- In RESYNC, count==prev is treated as a non-exp value in both builds.

Test Plan:
1. Reset, enable=1, count 0,1,...,31,0,1, evt_ready=1:
   - locked=1 after the first sample.
   - Exactly one event: WRAP, value 0.
   - wrap_count=1, error_count=0.
2. Locked at 5, then count=9, then 12, then 13:
   - One MISMATCH event with value 9.
   - error_count=2; locked=0 after 9.
   - locked=1 after 13.
3. evt_ready=0, force 6 mismatch-producing samples with RESYNC exits between them:
   - evt_valid stays 1; first 4 events retained in order; overflow=1.
   - Raise evt_ready: exactly 4 pops, then evt_valid=0.
4. FIFO full plus a new event with evt_ready=1 on the same edge:
   - Head pops, new event is stored, overflow stays 0, occupancy stays 4.
5. Count repeats 7,7,8:
   - With COUNT_CHECKER_STALL_EN: one STALL event, value 7; error_count=1.
   - Without: no events, error_count=0.
6. Assert reset with 3 events queued and error_count=3:
   - All outputs go to 0 immediately, without a clock edge.
   - After release, the first sample re-locks with no event.
